// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_pkg
//  Purpose  : Shared types and helpers for the HI/LO multiply/divide unit
//  Revision : 1.0  initial release
// ============================================================================
package hilo_pkg;

   localparam int HILO_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } hilo_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } hilo_state_t;

   function automatic logic is_mul_op(input hilo_op_t op);
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic is_div_op(input hilo_op_t op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   function automatic logic is_signed_op(input hilo_op_t op);
      return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
   endfunction

   function automatic logic is_acc_op(input hilo_op_t op);
      return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_divider.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_divider
//  Purpose  : Iterative restoring divider on unsigned magnitudes, one quotient
//             bit per cycle. The first bit is produced on the start edge, so
//             o_done rises in the cycle whose edge produces the last bit and
//             o_quot/o_rem are the final values during that cycle.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_divider
   import hilo_pkg::*;
#(
   parameter int WIDTH = HILO_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem
);

   localparam int DIV_CNT_W = $clog2(WIDTH) + 1;

   logic                 r_run;
   logic [DIV_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_dvs;

   logic [WIDTH-1:0]     w_rem_in;
   logic [WIDTH-1:0]     w_quo_in;
   logic [WIDTH-1:0]     w_dvs;
   logic [WIDTH:0]       w_part;
   logic [WIDTH:0]       w_trial;
   logic                 w_qbit;

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      w_rem_in = i_start ? '0         : r_rem;
      w_quo_in = i_start ? i_dividend : r_quo;
      w_dvs    = i_start ? i_divisor  : r_dvs;
      w_part   = {w_rem_in, w_quo_in[WIDTH-1]};
      w_trial  = w_part - {1'b0, w_dvs};
      w_qbit   = ~w_trial[WIDTH];
      o_rem    = w_qbit ? w_trial[WIDTH-1:0] : w_part[WIDTH-1:0];
      o_quot   = {w_quo_in[WIDTH-2:0], w_qbit};
      o_done   = r_run && (r_cnt == DIV_CNT_W'(WIDTH - 1));
   end

   // Iteration state: partial remainder, shifting quotient, step counter
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= DIV_CNT_W'(1);
         r_rem <= o_rem;
         r_quo <= o_quot;
         r_dvs <= i_divisor;
      end else if (r_run) begin
         r_rem <= o_rem;
         r_quo <= o_quot;
         r_cnt <= r_cnt + 1'b1;
         if (o_done) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit
//  Purpose  : HI/LO execution unit. Owns HI and LO, runs MULT/MADD/MSUB
//             (signed and unsigned) on a MUL_STAGES-deep product pipe and
//             DIV/DIVU on an iterative divider, and serves MTHI/MTLO.
//  Options  : define HILO_DIV_ZERO_SKIP_EN to finish divide-by-zero in one
//             cycle without touching HI/LO.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH      = HILO_WIDTH,
   parameter int MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MCNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) + 1 : 1;

   hilo_state_t         r_state;
   hilo_state_t         w_state_nxt;
   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;
   logic                r_done;
   logic [MCNT_W-1:0]   r_mcnt;
   logic                r_neg_q;
   logic                r_neg_r;

   hilo_op_t            w_op;
   logic                w_busy;
   logic                w_is_mul;
   logic                w_is_div;
   logic                w_signed;
   logic                w_accept;
   logic                w_start_div;
   logic                w_mul_commit;
   logic                w_div_commit;
   logic                w_done_nxt;
   logic                w_div_done;
   logic [2*WIDTH-1:0]  w_acc;
   logic [2*WIDTH-1:0]  w_ax;
   logic [2*WIDTH-1:0]  w_bx;
   logic [2*WIDTH-1:0]  w_prod;
   logic [2*WIDTH-1:0]  w_mul_res;
   logic [2*WIDTH-1:0]  w_mul_out;
   logic [WIDTH-1:0]    w_amag;
   logic [WIDTH-1:0]    w_bmag;
   logic [WIDTH-1:0]    w_dq;
   logic [WIDTH-1:0]    w_dr;
   logic [WIDTH-1:0]    w_q_fix;
   logic [WIDTH-1:0]    w_r_fix;

   assign w_op     = hilo_op_t'(op);
   assign w_is_mul = is_mul_op(w_op);
   assign w_is_div = is_div_op(w_op);
   assign w_signed = is_signed_op(w_op);
   assign w_busy   = (r_state != S_IDLE);
   assign busy     = w_busy;
   assign done     = r_done;
   assign hi       = r_hi;
   assign lo       = r_lo;

   // Product and accumulate; 2W-bit operands so truncation gives the exact
   // signed or unsigned product modulo 2^(2W)
   always_comb begin
      w_acc  = {r_hi, r_lo};
      w_ax   = w_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      w_bx   = w_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      w_prod = w_ax * w_bx;
      if (w_op == OP_MSUB || w_op == OP_MSUBU) begin
         w_mul_res = w_acc - w_prod;
      end else if (is_acc_op(w_op)) begin
         w_mul_res = w_acc + w_prod;
      end else begin
         w_mul_res = w_prod;
      end
   end

   generate
      if (MUL_STAGES > 1) begin : g_mul_pipe
         logic [2*WIDTH-1:0] r_pipe [MUL_STAGES-1];
         // Result shift; the counter decides which slot is committed
         always_ff @(posedge clk) begin
            r_pipe[0] <= w_mul_res;
            for (int i = 1; i < MUL_STAGES - 1; i++) begin
               r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_mul_out = r_pipe[MUL_STAGES-2];
      end else begin : g_mul_comb
         assign w_mul_out = w_mul_res;
      end
   endgenerate

   // Divider sees magnitudes; signs are reapplied on commit
   assign w_amag = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign w_bmag = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

   hilo_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk        (clk),
      .rst        (reset),
      .i_start    (w_start_div),
      .i_flush    (flush),
      .i_dividend (w_amag),
      .i_divisor  (w_bmag),
      .o_done     (w_div_done),
      .o_quot     (w_dq),
      .o_rem      (w_dr)
   );

   assign w_q_fix = r_neg_q ? (~w_dq + 1'b1) : w_dq;
   assign w_r_fix = r_neg_r ? (~w_dr + 1'b1) : w_dr;

   // Next-state and control strobes; flush overrides everything
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_start_div  = 1'b0;
      w_mul_commit = 1'b0;
      w_div_commit = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid_in && (w_is_mul || w_is_div)) begin
               w_accept = 1'b1;
               if (w_is_mul) begin
                  if (MUL_STAGES == 1) begin
                     w_mul_commit = 1'b1;
                     w_done_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = S_MUL;
                  end
               end else begin
`ifdef HILO_DIV_ZERO_SKIP_EN
                  if (b == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_start_div = 1'b1;
                     w_state_nxt = S_DIV;
                  end
`else
                  w_start_div = 1'b1;
                  w_state_nxt = S_DIV;
`endif
               end
            end
         end
         S_MUL: begin
            if (r_mcnt == MCNT_W'(MUL_STAGES - 1)) begin
               w_mul_commit = 1'b1;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_IDLE;
            end
         end
         S_DIV: begin
            if (w_div_done) begin
               w_div_commit = 1'b1;
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (flush) begin
         w_state_nxt  = S_IDLE;
         w_accept     = 1'b0;
         w_start_div  = 1'b0;
         w_mul_commit = 1'b0;
         w_div_commit = 1'b0;
         w_done_nxt   = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // HI/LO, done pulse, multiply counter and divide sign flags; a commit
   // lands after an MTHI/MTLO on the same edge so the op result wins
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
         r_mcnt  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         if (!w_busy) begin
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
         end
         if (w_mul_commit) begin
            {r_hi, r_lo} <= w_mul_out;
         end else if (w_div_commit) begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
         end
         if (w_accept) begin
            r_mcnt <= MCNT_W'(1);
         end else if (r_state == S_MUL) begin
            r_mcnt <= r_mcnt + 1'b1;
         end
         if (w_start_div) begin
            // A zero divisor keeps the all-ones quotient unsigned
            r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            r_neg_r <= w_signed && a[WIDTH-1];
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Sequential HI/LO execution unit for the MIPS core.
- Owns the architectural HI and LO registers.
- Executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU on a fixed-latency multiplier and DIV/DIVU on an iterative radix-2 divider.
- Serves MTHI/MTLO writes and exposes HI/LO to MFHI/MFLO readers. The execute stage drives it and stalls while it is busy.

Parameters:
- WIDTH, 32, data width of operands and of each of HI and LO.
- MUL_STAGES, 2, multiply latency in cycles (>=1).
- DIV_CNT_W, $clog2(WIDTH)+1, width of the divide iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  start request for a mul/div op
- op  in  3  hilo_op_t: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- wr_hi  in  1  MTHI strobe
- wr_lo  in  1  MTLO strobe
- wdata  in  WIDTH  MTHI/MTLO data
- flush  in  1  abort in-flight op (exception/eret)
- busy  out  1  op in flight; upstream must stall
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, on port `reset`.
- Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset mid-operation discards the op; no done pulse follows.
- FSM states: IDLE, MUL, DIV.
- Accept: op is accepted at edge k when valid_in & ~busy & ~flush. Operands and the {hi,lo} accumulator are sampled at that edge.
  - Mul ops -> MUL; div ops -> DIV.
- Multiply: signed for MULT/MADD/MSUB, unsigned for the U variants. Full 2*WIDTH-bit product.
  - MADD*: {hi,lo} + product. MSUB*: {hi,lo} - product. Both mod 2^(2*WIDTH).
  - busy=1 in cycles k+1..k+MUL_STAGES-1. The result commits so that hi/lo are new and done=1 in cycle k+MUL_STAGES, with busy=0 in that cycle.
  - MUL_STAGES=1: busy is never raised; done appears in cycle k+1.
- Divide: lo=quotient, hi=remainder.
  - DIV operates on magnitudes. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/-1: lo=MIN, hi=0.
  - One quotient bit per cycle. busy=1 in cycles k+1..k+WIDTH-1; done with new hi/lo in cycle k+WIDTH.
  - Divisor zero (macro absent): runs the full WIDTH iterations; lo=all-ones, hi=a.
- done: high exactly one cycle per completed op; low otherwise.
- Back-to-back: a new valid_in is accepted in the done cycle. Its accumulator sample sees the freshly committed hi/lo.
- MTHI/MTLO: honoured only when ~busy. hi<=wdata (or lo<=wdata) at the edge.
  - Ignored while busy; upstream guarantees a stall.
  - If asserted at the same edge as an accept, the write lands, then is overwritten by the op's commit. The MADD/MSUB accumulator uses the pre-write value.
  - wr_hi & wr_lo together write both.
- flush: at edge, FSM->IDLE. Both busy and done are 0 in the next cycle; hi/lo are unchanged.
  - A flush in the same cycle as valid_in rejects the start.
  - Flush during a done cycle does not undo the commit.
  - Flush with MTHI/MTLO: the write is still honoured if ~busy.
- op outside the enum with valid_in: no state change.

Optional Feature:
- Macro: HILO_DIV_ZERO_SKIP_EN.
- Defined: DIV/DIVU with b==0 commits nothing. FSM returns to IDLE; done pulses in cycle k+1; hi/lo are unchanged.
- Undefined: full-latency zero-divisor behaviour as stated in Behaviour.

Decomposition:
- Package hilo_pkg holds:
  - hilo_op_t enum (3 bits)
  - hilo_state_t
  - is_mul_op / is_signed_op / is_acc_op helper functions
  - default WIDTH constant
- One sub-module: hilo_divider, the iterative restoring divider with start/flush/done, magnitude inputs, and sign fix-up outside it.
- Multiplier is an inline MUL_STAGES-deep shift of the product register.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 accepted at k -> cycle k+2: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=1 only at k+1.
- DIVU a=100, b=7 -> cycle k+32: lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MTLO 10, MTHI 0, then MADD 3*4 -> {hi,lo}={0,22}; then MSUBU 0*?... MSUBU a=1, b=23 -> {0xFFFFFFFF,0xFFFFFFFF}.
- DIVU started, flush at k+5 -> busy=0 at k+6, done never pulses, hi/lo keep prior values; same sequence with reset -> hi=lo=0.
- DIVU a=9, b=0: macro off -> done at k+32, lo=0xFFFFFFFF, hi=9; macro on -> done at k+1, hi/lo unchanged.
- MTHI 0x55 while busy -> ignored; MTHI 0x55 with simultaneous MULTU 2*3 accept -> hi=0x55 next cycle, then hi=0, lo=6 at done.
